// File: rtl/rr_index_arb.sv
// rr_index_arb: round-robin arbiter over M = 1<<N requesters. The winner is presented as a
// registered binary index (gnt_idx) qualified by gnt_vld; a downstream decode_n turns it into
// the one-hot grant bus. A grant is held until the owner pulses done; the search pointer then
// moves to the slot after the released owner so every requester gets fair service.
//
// Optional feature: define ARB_TIMEOUT_EN to add a watchdog that force-releases a grant after
// TIMEOUT grant cycles without done, and a timeout output that pulses once per forced release.
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   req      in   M  request vector, bit i is requester i
//   done     in   1  current owner releases its grant
//   gnt_idx  out  N  index of the current owner (registered)
//   gnt_vld  out  1  gnt_idx is valid
//   timeout  out  1  one-cycle pulse after a forced release (ARB_TIMEOUT_EN only)
module rr_index_arb #(
  parameter int unsigned N       = 4,
  parameter int unsigned M       = 1 << N,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] req,
  input  logic         done,
  output logic [N-1:0] gnt_idx,
  output logic         gnt_vld
`ifdef ARB_TIMEOUT_EN
  ,
  output logic         timeout
`endif
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StGrant = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] ptr_q, ptr_d;
  logic [N-1:0] idx_q, idx_d;
  logic [N-1:0] win_idx;
  logic         win_found;
  logic         rel;

  // Circular scan upward from ptr; the N-bit add wraps M-1 back to 0.
  always_comb begin
    logic [N-1:0] cand;
    win_idx   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < M; i++) begin
      cand = ptr_q + N'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            expire;
  logic            timeout_q, timeout_d;

  // cnt_q counts grant cycles already completed, so expiry lands at the end of the
  // TIMEOUT-th grant cycle.
  assign expire    = (state_q == StGrant) && (cnt_q == CntW'(TIMEOUT - 1));
  assign rel       = (state_q == StGrant) && (done || expire);
  assign cnt_d     = (state_q == StGrant) ? cnt_q + CntW'(1) : '0;
  // A done coinciding with expiry is an ordinary release, so no pulse.
  assign timeout_d = expire && !done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign rel = (state_q == StGrant) && done;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          idx_d   = win_idx;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (rel) begin
          ptr_d   = idx_q + N'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
    end
  end

  assign gnt_idx = idx_q;
  assign gnt_vld = (state_q == StGrant);

endmodule

// File: tb/tb_rr_index_arb.sv
// Directed bench for rr_index_arb (N=4, M=16, TIMEOUT=4). Inputs change 1 ns after each rising
// edge and outputs are checked at the same point, well away from the next edge.
module tb_rr_index_arb;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
`ifdef ARB_TIMEOUT_EN
  logic        timeout;
  localparam int HoldCycles = 2;
`else
  localparam int HoldCycles = 5;
`endif

  int total = 0;
  int bad   = 0;

  rr_index_arb #(
    .N       (4),
    .M       (16),
    .TIMEOUT (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout (timeout)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic exp_vld, input logic [3:0] exp_idx);
    total++;
    assert (gnt_vld === exp_vld) else begin
      bad++;
      $error("FAIL %s gnt_vld observed=%0b expected=%0b", tag, gnt_vld, exp_vld);
    end
    total++;
    assert (gnt_idx === exp_idx) else begin
      bad++;
      $error("FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx, exp_idx);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic check_to(input string tag, input logic exp_to);
    total++;
    assert (timeout === exp_to) else begin
      bad++;
      $error("FAIL %s timeout observed=%0b expected=%0b", tag, timeout, exp_to);
    end
  endtask
`endif

  // Release the current owner (prev), expect one idle cycle holding prev, then grant nxt.
  task automatic release_regrant(input string tag, input logic [3:0] prev, input logic [3:0] nxt);
    done = 1'b1;
    tick();
    check_out({tag, "_idle"}, 1'b0, prev);
`ifdef ARB_TIMEOUT_EN
    check_to({tag, "_idle_to"}, 1'b0);
`endif
    done = 1'b0;
    tick();
    check_out({tag, "_gnt"}, 1'b1, nxt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = 16'hFFFF;
    done  = 1'b0;

    // Reset state with every requester active.
    tick();
    tick();
    check_out("reset", 1'b0, 4'd0);
`ifdef ARB_TIMEOUT_EN
    check_to("reset_to", 1'b0);
`endif
    rst_n = 1'b1;
    tick();
    check_out("first_grant", 1'b1, 4'd0);

    // Rotation 0..15 then wrap to 0.
    for (int k = 1; k <= 16; k++) begin
      release_regrant("rotate", 4'((k - 1) % 16), 4'(k % 16));
    end

    // Sparse requests from ptr=0.
    req   = 16'h0000;
    rst_n = 1'b0;
    #2;
    check_out("sparse_reset", 1'b0, 4'd0);
    rst_n = 1'b1;
    req   = 16'h8005;
    tick();
    check_out("sparse_g0", 1'b1, 4'd0);
    release_regrant("sparse_g2", 4'd0, 4'd2);
    release_regrant("sparse_g15", 4'd2, 4'd15);
    release_regrant("sparse_g0b", 4'd15, 4'd0);
    release_regrant("sparse_g2b", 4'd0, 4'd2);
    release_regrant("sparse_g15b", 4'd2, 4'd15);
    req = 16'h0001;
    release_regrant("sparse_wrap", 4'd15, 4'd0);

    // Hold: owner drops req, another raises it; grant must not move.
    req = 16'h0004;
    release_regrant("hold_g2", 4'd0, 4'd2);
    req = 16'h0008;
    for (int k = 0; k < HoldCycles; k++) begin
      tick();
      check_out("hold_keep", 1'b1, 4'd2);
    end
    release_regrant("hold_g3", 4'd2, 4'd3);

    // done while idle must not move ptr (ptr=4 after releasing 3).
    req  = 16'h0000;
    done = 1'b1;
    tick();
    check_out("idle_done_rel", 1'b0, 4'd3);
    tick();
    check_out("idle_done_1", 1'b0, 4'd3);
    tick();
    check_out("idle_done_2", 1'b0, 4'd3);
    done = 1'b0;
    req  = 16'hFFFF;
    tick();
    check_out("idle_done_g4", 1'b1, 4'd4);

    // Async reset mid-grant at 7 (ptr=5 before reset).
    req = 16'h0080;
    release_regrant("async_g7", 4'd4, 4'd7);
    #3;
    rst_n = 1'b0;
    #1;
    check_out("async_drop", 1'b0, 4'd0);
`ifdef ARB_TIMEOUT_EN
    check_to("async_to", 1'b0);
`endif
    req = 16'hFFFF;
    tick();
    check_out("async_held", 1'b0, 4'd0);
    rst_n = 1'b1;
    tick();
    check_out("async_after", 1'b1, 4'd0);

`ifdef ARB_TIMEOUT_EN
    // Forced release of grant 5 after 4 grant cycles.
    req = 16'h0020;
    release_regrant("to_g5", 4'd0, 4'd5);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("to_hold", 1'b1, 4'd5);
      check_to("to_hold_to", 1'b0);
    end
    req = 16'hFFFF;
    tick();
    check_out("to_force", 1'b0, 4'd5);
    check_to("to_pulse", 1'b1);
    tick();
    check_out("to_next6", 1'b1, 4'd6);
    check_to("to_pulse_end", 1'b0);

    // done exactly on the expiry cycle: normal release, no pulse.
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("tod_hold", 1'b1, 4'd6);
    end
    done = 1'b1;
    tick();
    check_out("tod_rel", 1'b0, 4'd6);
    check_to("tod_nopulse", 1'b0);
    done = 1'b0;
    tick();
    check_out("tod_next7", 1'b1, 4'd7);
    check_to("tod_next_to", 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_index_arb.md
# rr_index_arb

Round-robin arbiter that selects one of `M = 1<<N` requesters and presents the winner as a registered binary index plus valid. It sits directly upstream of `decode_n`. Its `gnt_idx` drives `decode_n.in`, so `decode_n.y` becomes the one-hot grant bus, qualified by `gnt_vld`. Each grant is held until the owner signals `done`; the search pointer then rotates so every requester gets fair service.

## Interface
- `N`, default 4: index width; also the `decode_n` `n`.
- `M`, default `1<<N`: number of requesters; must equal `1<<N`.
- `TIMEOUT`, default 16: watchdog limit in cycles, at least 2; used only with `ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  M  request vector; bit i is requester i.
- `done`  in  1  current owner releases its grant.
- `gnt_idx`  out  N  index of the current owner (registered).
- `gnt_vld`  out  1  `gnt_idx` is valid; the one-hot grant is `decode_n(gnt_idx)` & `gnt_vld`.
- `timeout`  out  1  one-cycle pulse on a forced release; port exists only with `ARB_TIMEOUT_EN`.

## Operation
- FSM has two states:
  - **IDLE** (reset state).
  - **GRANT**.
- IDLE:
  - If `req` != 0, pick the first set bit scanning circularly upward from `ptr` (`ptr`, `ptr+1`, … , `M-1`, 0, … , `ptr-1`).
  - Register the winner into `gnt_idx`, set `gnt_vld`=1, go to GRANT.
  - If `req` == 0, stay in IDLE; `gnt_idx` holds its previous value.
- GRANT:
  - Hold `gnt_idx` and `gnt_vld`=1 until `done`=1 is sampled.
  - On `done`: `gnt_vld`←0, `ptr`←(`gnt_idx`+1) mod M (natural N-bit wrap, so index M-1 wraps to 0), go to IDLE.
- Owner dropping its `req` while in GRANT has no effect; only `done` (or the timeout) releases the grant.
- `done` sampled in IDLE is ignored and does not move `ptr`.
- Other requests arriving during GRANT wait; they are arbitrated in the next IDLE cycle using the updated `ptr`.
- `ptr` is N bits wide, resets to 0, and changes only on release.
- Reset asserted mid-grant: immediately (asynchronously) forces IDLE, `ptr`=0, `gnt_idx`=0, `gnt_vld`=0, `timeout`=0.

## Timing
- Reset values: `gnt_idx`=0, `gnt_vld`=0, `timeout`=0, `ptr`=0, state IDLE.
- Grant latency: a `req` sampled at edge k in IDLE gives `gnt_vld`=1 with a valid `gnt_idx` after edge k (1 cycle).
- Release latency: `done` sampled at edge k gives `gnt_vld`=0 after edge k.
- Gap between grants: `gnt_vld` is low for exactly one cycle between consecutive grants, even with continuous requests.
  - Minimum period per grant is therefore 2 cycles (grant cycle + done, then the IDLE cycle).
- `gnt_idx` never changes while `gnt_vld`=1.
- All outputs come straight from flops; there is no combinational path from any input to any output.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to GRANT and increments each GRANT cycle.
  - If `done` has not arrived once `TIMEOUT` GRANT cycles have elapsed, the grant is force-released exactly as if `done` had been sampled (`ptr` advances).
  - `timeout` pulses high for the one cycle in which `gnt_vld` first reads 0 after a forced release.
  - If `done` arrives in the same cycle as expiry, it is a normal release and no `timeout` pulse occurs.
- `ARB_TIMEOUT_EN` undefined: no counter and no `timeout` port; grants are held indefinitely until `done`.

## Test plan
Each scenario uses N=4, M=16.
- **Reset state:** `rst_n`=0 with `req`=16'hFFFF → `gnt_vld`=0, `gnt_idx`=0. Release reset → first grant is `gnt_idx`=0 one cycle later.
- **Rotation:** hold `req`=16'hFFFF and pulse `done` on every grant → `gnt_idx` sequence is 0, 1, 2, … , 15, 0 (wrap). Each grant is separated by one `gnt_vld`=0 cycle.
- **Sparse requests:** `req`=16'h8005 starting from `ptr`=0 → grants 0, 2, 15, 0.
  - Then after releasing 15 with `req`=16'h0001, the next grant is 0.
- **Hold / ignore:** while granted to 2, drop `req`[2] and raise `req`[3] for 5 cycles → `gnt_idx` stays 2. Assert `done` → next grant is 3. Also, `done` pulsed in IDLE leaves `ptr` unchanged.
- **Async reset mid-grant:** grant at 7, then `rst_n`=0 between edges → `gnt_vld` and `gnt_idx` drop to 0 immediately. After reset the next grant comes from `ptr`=0.
- **Timeout (with `ARB_TIMEOUT_EN`, `TIMEOUT`=4):** grant at 5 with no `done` → force release after 4 GRANT cycles, one-cycle `timeout` pulse, next grant searches from 6. With `done` on the expiry cycle → no `timeout` pulse.
